vga_frame_monitor: RTL and testbench

- Receive-side checker for the Pong VGA output. It consumes h_sync, v_sync and rgb, and reconstructs pixel coordinates from the sync edges.
- It checks frame timing against 640x480 VGA and extracts ball and paddle bounding boxes by colour match.
- At each frame boundary it reports positions, so benches and on-board logic can cross-check the video stream against the game state.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_bbox_tracker.sv | 72 +++++++
 rtl/vga_frame_monitor.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, colour constants and monitor FSM encoding.
// Latency: n/a, constants and a pure helper function only.
// Backpressure: n/a.
package vga_pkg;

   // 640x480 @ 60 Hz timing defaults
   localparam int DFLT_H_ACTIVE = 640;
   localparam int DFLT_H_FP     = 16;
   localparam int DFLT_H_SYNC   = 96;
   localparam int DFLT_H_BP     = 48;
   localparam int DFLT_V_ACTIVE = 480;
   localparam int DFLT_V_FP     = 10;
   localparam int DFLT_V_SYNC   = 2;
   localparam int DFLT_V_BP     = 33;

   localparam int H_TOTAL = DFLT_H_ACTIVE + DFLT_H_FP + DFLT_H_SYNC + DFLT_H_BP;
   localparam int V_TOTAL = DFLT_V_ACTIVE + DFLT_V_FP + DFLT_V_SYNC + DFLT_V_BP;

   // Both syncs are active low on the Pong output
   localparam logic        DFLT_SYNC_ACT   = 1'b0;
   localparam logic [11:0] DFLT_BALL_RGB   = 12'hFFF;
   localparam logic [11:0] DFLT_PADDLE_RGB = 12'h0F0;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_MEASURE  = 2'd1,
      ST_LOCKED   = 2'd2
   } mon_state_e;

   // Inclusive box extent from min/max coordinates
   function automatic logic [9:0] box_size(input logic [9:0] lo, input logic [9:0] hi);
      return hi - lo + 10'd1;
   endfunction

endpackage

// File: rtl/vga_bbox_tracker.sv
// vga_bbox_tracker: running min/max bounding box of the pixels flagged by hit within one frame.
// Latency: box registers reflect a hit one clk later; clear and hit in the same clk start a new box.
// Backpressure: none, a hit is accepted every clock.
module vga_bbox_tracker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       hit,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic       found,
   output logic [9:0] min_x,
   output logic [9:0] max_x,
   output logic [9:0] min_y,
   output logic [9:0] max_y
);

   logic       found_q, found_d;
   logic [9:0] min_x_q, min_x_d;
   logic [9:0] max_x_q, max_x_d;
   logic [9:0] min_y_q, min_y_d;
   logic [9:0] max_y_q, max_y_d;
   logic       base_found;

   // Grow the box with each hit; the first hit after a clear seeds all four edges
   always_comb begin
      base_found = clear ? 1'b0 : found_q;
      found_d    = base_found;
      min_x_d    = min_x_q;
      max_x_d    = max_x_q;
      min_y_d    = min_y_q;
      max_y_d    = max_y_q;
      if (hit) begin
         found_d = 1'b1;
         if (!base_found) begin
            min_x_d = x;
            max_x_d = x;
            min_y_d = y;
            max_y_d = y;
         end else begin
            if (x < min_x_q) min_x_d = x;
            if (x > max_x_q) max_x_d = x;
            if (y < min_y_q) min_y_d = y;
            if (y > max_y_q) max_y_d = y;
         end
      end
   end

   // Box state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         found_q <= 1'b0;
         min_x_q <= '0;
         max_x_q <= '0;
         min_y_q <= '0;
         max_y_q <= '0;
      end else begin
         found_q <= found_d;
         min_x_q <= min_x_d;
         max_x_q <= max_x_d;
         min_y_q <= min_y_d;
         max_y_q <= max_y_d;
      end
   end

   assign found = found_q;
   assign min_x = min_x_q;
   assign max_x = max_x_q;
   assign min_y = min_y_q;
   assign max_y = max_y_q;

endmodule

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: checks VGA sync timing, tracks ball/paddle boxes by colour, reports per frame.
// Latency: inputs registered on pix_en; report registers and frame_valid update 1 clk after the sampled vsync edge.
// Backpressure: none, pix_en strobes are consumed unconditionally; pix_en low freezes all state.
module vga_frame_monitor
   import vga_pkg::*;
#(
   parameter int          H_ACTIVE   = DFLT_H_ACTIVE,
   parameter int          H_FP       = DFLT_H_FP,
   parameter int          H_SYNC     = DFLT_H_SYNC,
   parameter int          H_BP       = DFLT_H_BP,
   parameter int          V_ACTIVE   = DFLT_V_ACTIVE,
   parameter int          V_FP       = DFLT_V_FP,
   parameter int          V_SYNC     = DFLT_V_SYNC,
   parameter int          V_BP       = DFLT_V_BP,
   parameter logic        SYNC_ACT   = DFLT_SYNC_ACT,
   parameter logic [11:0] BALL_RGB   = DFLT_BALL_RGB,
   parameter logic [11:0] PADDLE_RGB = DFLT_PADDLE_RGB
) (
   input  logic        clk,
   input  logic        reset_in,
   input  logic        pix_en,
   input  logic        h_sync,
   input  logic        v_sync,
   input  logic [11:0] rgb,
   output logic        locked,
   output logic        frame_valid,
   output logic        ball_found,
   output logic [9:0]  ball_x,
   output logic [9:0]  ball_y,
   output logic [9:0]  ball_w,
   output logic [9:0]  ball_h,
   output logic        paddle_found,
   output logic [9:0]  paddle_x,
   output logic [9:0]  paddle_y,
   output logic        timing_err,
   output logic        blank_err,
   output logic [15:0] frame_count
);

   localparam logic [9:0] H_TOT   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam logic [9:0] V_TOT   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   // h_cnt is 0 on the hsync edge pixel; lines is 1 on the first line of a frame
   localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0] V_START = 10'(V_SYNC + V_BP + 1);
   localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + 1 + V_ACTIVE);

   // Input sample stage
   logic        pix_vld_q, pix_vld_d;
   logic        hs_q, hs_d, hs_prev_q, hs_prev_d;
   logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
   logic [11:0] rgb_q, rgb_d;

   // Monitor state
   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  lines_q, lines_d;
   logic        h_seen_q, h_seen_d;
   logic        frame_bad_q, frame_bad_d;
   mon_state_e  state_q, state_d;
   logic        locked_q, locked_d;
   logic        timing_err_q, timing_err_d;
   logic        blank_err_q, blank_err_d;
   logic        frame_valid_q, frame_valid_d;
   logic        ball_found_q, ball_found_d;
   logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic [9:0]  ball_w_q, ball_w_d, ball_h_q, ball_h_d;
   logic        paddle_found_q, paddle_found_d;
   logic [9:0]  paddle_x_q, paddle_x_d, paddle_y_q, paddle_y_d;
   logic [15:0] frame_count_q, frame_count_d;

   // Per-pixel decode
   logic        h_edge, v_edge, line_err, frame_err, bad_frame, report_en;
   logic        in_active, ball_match, paddle_match, ball_hit, paddle_hit;
   logic [9:0]  pix_x, pix_y;

   // Tracker outputs
   logic        b_found, p_found;
   logic [9:0]  b_min_x, b_max_x, b_min_y, b_max_y;
   logic [9:0]  p_min_x, p_max_x, p_min_y, p_max_y;

   // Capture syncs and colour on each pixel strobe, keeping the previous sync sample for edge detection
   always_comb begin
      pix_vld_d = pix_en;
      hs_d      = hs_q;
      vs_d      = vs_q;
      hs_prev_d = hs_prev_q;
      vs_prev_d = vs_prev_q;
      rgb_d     = rgb_q;
      if (pix_en) begin
         hs_prev_d = hs_q;
         vs_prev_d = vs_q;
         hs_d      = h_sync;
         vs_d      = v_sync;
         rgb_d     = rgb;
      end
   end

   // Sync edges, pixel/line counters, line and frame length checks, active-area decode
   always_comb begin
      h_edge   = pix_vld_q && (hs_q == SYNC_ACT) && (hs_prev_q != SYNC_ACT);
      v_edge   = pix_vld_q && (vs_q == SYNC_ACT) && (vs_prev_q != SYNC_ACT);
      h_cnt_d  = h_cnt_q;
      lines_d  = lines_q;
      h_seen_d = h_seen_q;
      if (pix_vld_q) begin
         h_cnt_d = h_edge ? 10'd0 : h_cnt_q + 10'd1;
      end
      if (h_edge) begin
         lines_d  = lines_q + 10'd1;
         h_seen_d = 1'b1;
      end
      // A coincident hsync edge is the first line of the new frame
      if (v_edge) begin
         lines_d = h_edge ? 10'd1 : 10'd0;
      end
      // The closing line is checked against the old frame before the frame length check
      line_err  = h_edge && h_seen_q && ((h_cnt_q + 10'd1) != H_TOT);
      frame_err = v_edge && (lines_q != V_TOT);
      in_active = pix_vld_q && (h_cnt_d >= H_START) && (h_cnt_d < H_END)
                  && (lines_d >= V_START) && (lines_d < V_END);
      pix_x        = h_cnt_d - H_START;
      pix_y        = lines_d - V_START;
      ball_match   = (rgb_q == BALL_RGB);
      paddle_match = (rgb_q == PADDLE_RGB) && !ball_match;
      ball_hit     = in_active && (state_q == ST_LOCKED) && ball_match;
      paddle_hit   = in_active && (state_q == ST_LOCKED) && paddle_match;
   end

   vga_bbox_tracker u_ball_box (
      .clk   (clk),
      .rst_n (reset_in),
      .clear (v_edge),
      .hit   (ball_hit),
      .x     (pix_x),
      .y     (pix_y),
      .found (b_found),
      .min_x (b_min_x),
      .max_x (b_max_x),
      .min_y (b_min_y),
      .max_y (b_max_y)
   );

   vga_bbox_tracker u_paddle_box (
      .clk   (clk),
      .rst_n (reset_in),
      .clear (v_edge),
      .hit   (paddle_hit),
      .x     (pix_x),
      .y     (pix_y),
      .found (p_found),
      .min_x (p_min_x),
      .max_x (p_max_x),
      .min_y (p_min_y),
      .max_y (p_max_y)
   );

   // Lock FSM, sticky error flags and the per-frame report; a bad frame is never reported
   always_comb begin
      state_d        = state_q;
      frame_bad_d    = frame_bad_q || line_err;
      timing_err_d   = timing_err_q;
      blank_err_d    = blank_err_q;
      frame_valid_d  = 1'b0;
      report_en      = 1'b0;
      ball_found_d   = ball_found_q;
      ball_x_d       = ball_x_q;
      ball_y_d       = ball_y_q;
      ball_w_d       = ball_w_q;
      ball_h_d       = ball_h_q;
      paddle_found_d = paddle_found_q;
      paddle_x_d     = paddle_x_q;
      paddle_y_d     = paddle_y_q;
      frame_count_d  = frame_count_q;
      bad_frame      = frame_bad_q || line_err || frame_err;

      if ((state_q != ST_UNLOCKED) && (line_err || frame_err)) timing_err_d = 1'b1;
      if (pix_vld_q && !in_active && (state_q == ST_LOCKED) && (rgb_q != 12'd0)) blank_err_d = 1'b1;

      if (v_edge) begin
         frame_bad_d = 1'b0;
         case (state_q)
            ST_UNLOCKED: state_d = ST_MEASURE;
            ST_MEASURE:  state_d = bad_frame ? ST_MEASURE : ST_LOCKED;
            ST_LOCKED: begin
               if (bad_frame) state_d = ST_MEASURE;
               else           report_en = 1'b1;
            end
            default:     state_d = ST_UNLOCKED;
         endcase
      end

      if (report_en) begin
         frame_valid_d  = 1'b1;
         frame_count_d  = frame_count_q + 16'd1;
         ball_found_d   = b_found;
         paddle_found_d = p_found;
         // Coordinates hold their last value when the colour was absent
         if (b_found) begin
            ball_x_d = b_min_x;
            ball_y_d = b_min_y;
            ball_w_d = box_size(b_min_x, b_max_x);
            ball_h_d = box_size(b_min_y, b_max_y);
         end
         if (p_found) begin
            paddle_x_d = p_min_x;
            paddle_y_d = p_min_y;
         end
      end
      locked_d = (state_d == ST_LOCKED);
   end

   // Input sample registers
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         pix_vld_q <= 1'b0;
         hs_q      <= SYNC_ACT;
         vs_q      <= SYNC_ACT;
         hs_prev_q <= SYNC_ACT;
         vs_prev_q <= SYNC_ACT;
         rgb_q     <= '0;
      end else begin
         pix_vld_q <= pix_vld_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         hs_prev_q <= hs_prev_d;
         vs_prev_q <= vs_prev_d;
         rgb_q     <= rgb_d;
      end
   end

   // Monitor state, FSM and report registers
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         h_cnt_q        <= '0;
         lines_q        <= '0;
         h_seen_q       <= 1'b0;
         frame_bad_q    <= 1'b0;
         state_q        <= ST_UNLOCKED;
         locked_q       <= 1'b0;
         timing_err_q   <= 1'b0;
         blank_err_q    <= 1'b0;
         frame_valid_q  <= 1'b0;
         ball_found_q   <= 1'b0;
         ball_x_q       <= '0;
         ball_y_q       <= '0;
         ball_w_q       <= '0;
         ball_h_q       <= '0;
         paddle_found_q <= 1'b0;
         paddle_x_q     <= '0;
         paddle_y_q     <= '0;
         frame_count_q  <= '0;
      end else begin
         h_cnt_q        <= h_cnt_d;
         lines_q        <= lines_d;
         h_seen_q       <= h_seen_d;
         frame_bad_q    <= frame_bad_d;
         state_q        <= state_d;
         locked_q       <= locked_d;
         timing_err_q   <= timing_err_d;
         blank_err_q    <= blank_err_d;
         frame_valid_q  <= frame_valid_d;
         ball_found_q   <= ball_found_d;
         ball_x_q       <= ball_x_d;
         ball_y_q       <= ball_y_d;
         ball_w_q       <= ball_w_d;
         ball_h_q       <= ball_h_d;
         paddle_found_q <= paddle_found_d;
         paddle_x_q     <= paddle_x_d;
         paddle_y_q     <= paddle_y_d;
         frame_count_q  <= frame_count_d;
      end
   end

   assign locked       = locked_q;
   assign frame_valid  = frame_valid_q;
   assign ball_found   = ball_found_q;
   assign ball_x       = ball_x_q;
   assign ball_y       = ball_y_q;
   assign ball_w       = ball_w_q;
   assign ball_h       = ball_h_q;
   assign paddle_found = paddle_found_q;
   assign paddle_x     = paddle_x_q;
   assign paddle_y     = paddle_y_q;
   assign timing_err   = timing_err_q;
   assign blank_err    = blank_err_q;
   assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: directed frame streams on a reduced raster, reports checked through a scoreboard queue.
// Latency: expected reports queued at stimulus time, popped whenever frame_valid is seen.
// Backpressure: n/a, the bench drives one pixel per clock (or per two clocks in gap mode).
module tb_vga_frame_monitor;

   // Reduced raster: 56 x 37 keeps each frame near 2k clocks
   localparam int HA = 40, HF = 4, HS = 8, HB = 4;
   localparam int VA = 30, VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic        clk;
   logic        reset_in;
   logic        pix_en;
   logic        h_sync;
   logic        v_sync;
   logic [11:0] rgb;
   logic        locked;
   logic        frame_valid;
   logic        ball_found;
   logic [9:0]  ball_x, ball_y, ball_w, ball_h;
   logic        paddle_found;
   logic [9:0]  paddle_x, paddle_y;
   logic        timing_err;
   logic        blank_err;
   logic [15:0] frame_count;

   vga_frame_monitor #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_ACT(1'b0), .BALL_RGB(12'hFFF), .PADDLE_RGB(12'h0F0)
   ) dut (
      .clk          (clk),
      .reset_in     (reset_in),
      .pix_en       (pix_en),
      .h_sync       (h_sync),
      .v_sync       (v_sync),
      .rgb          (rgb),
      .locked       (locked),
      .frame_valid  (frame_valid),
      .ball_found   (ball_found),
      .ball_x       (ball_x),
      .ball_y       (ball_y),
      .ball_w       (ball_w),
      .ball_h       (ball_h),
      .paddle_found (paddle_found),
      .paddle_x     (paddle_x),
      .paddle_y     (paddle_y),
      .timing_err   (timing_err),
      .blank_err    (blank_err),
      .frame_count  (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        bf;
      logic [9:0]  bx, by, bw, bh;
      logic        pf;
      logic [9:0]  px, py;
      logic [15:0] cnt;
   } exp_t;

   exp_t expq[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   // Scene description used by the pixel generator
   int ball_on = 0, bx0 = 0, by0 = 0, bw0 = 0, bh0 = 0;
   int pad_on = 0, px0 = 0, py0 = 0, pw0 = 0, ph0 = 0;
   int blank_v = -1;
   int short_v = -1;
   int gap = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic push_exp(input logic bf, input int bx, input int by, input int bw, input int bh,
                           input logic pf, input int px, input int py, input int cnt);
      exp_t t;
      t.bf = bf; t.bx = 10'(bx); t.by = 10'(by); t.bw = 10'(bw); t.bh = 10'(bh);
      t.pf = pf; t.px = 10'(px); t.py = 10'(py); t.cnt = 16'(cnt);
      expq.push_back(t);
   endtask

   task automatic set_scene_a();
      ball_on = 1; bx0 = 10; by0 = 12; bw0 = 8; bh0 = 8;
      pad_on = 0; blank_v = -1; short_v = -1; gap = 0;
   endtask

   task automatic set_scene_b();
      ball_on = 1; bx0 = HA - 1; by0 = VA - 1; bw0 = 1; bh0 = 1;
      pad_on = 1; px0 = 2; py0 = 5; pw0 = 3; ph0 = 10;
      blank_v = -1; short_v = -1; gap = 0;
   endtask

   task automatic set_scene_black();
      ball_on = 0; pad_on = 0; blank_v = -1; short_v = -1; gap = 0;
   endtask

   function automatic logic [11:0] pix_colour(input int h, input int v);
      int x, y;
      x = h - (HS + HB);
      y = v - (VS + VB);
      if (v == blank_v && h == HS + HB + HA + 1) return 12'h00F;
      if (x < 0 || x >= HA || y < 0 || y >= VA) return 12'h000;
      if (ball_on != 0 && x >= bx0 && x < bx0 + bw0 && y >= by0 && y < by0 + bh0) return 12'hFFF;
      if (pad_on != 0 && x >= px0 && x < px0 + pw0 && y >= py0 && y < py0 + ph0) return 12'h0F0;
      return 12'h000;
   endfunction

   task automatic drive_rows(input int v0, input int v1);
      for (int v = v0; v < v1; v++) begin
         for (int h = 0; h < HT; h++) begin
            if (v == short_v && h == HT - 1) continue;
            @(posedge clk); #1;
            pix_en = 1'b1;
            h_sync = (h < HS) ? 1'b0 : 1'b1;
            v_sync = (v < VS) ? 1'b0 : 1'b1;
            rgb    = pix_colour(h, v);
            if (gap != 0) begin
               @(posedge clk); #1;
               pix_en = 1'b0;
               h_sync = ~h_sync;
               v_sync = ~v_sync;
               rgb    = 12'hFFF;
            end
         end
      end
      @(posedge clk); #1;
      pix_en = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_locked"}, 32'(locked), 32'd0);
      chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
      chk({tag, "_ball_found"}, 32'(ball_found), 32'd0);
      chk({tag, "_ball_x"}, 32'(ball_x), 32'd0);
      chk({tag, "_ball_y"}, 32'(ball_y), 32'd0);
      chk({tag, "_ball_w"}, 32'(ball_w), 32'd0);
      chk({tag, "_ball_h"}, 32'(ball_h), 32'd0);
      chk({tag, "_paddle_found"}, 32'(paddle_found), 32'd0);
      chk({tag, "_paddle_x"}, 32'(paddle_x), 32'd0);
      chk({tag, "_paddle_y"}, 32'(paddle_y), 32'd0);
      chk({tag, "_timing_err"}, 32'(timing_err), 32'd0);
      chk({tag, "_blank_err"}, 32'(blank_err), 32'd0);
      chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
   endtask

   // Monitor: every frame_valid pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (reset_in && frame_valid) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_valid: got frame_count %0d with no report expected", frame_count);
         end else begin
            e = expq.pop_front();
            chk("rep_ball_found", 32'(ball_found), 32'(e.bf));
            chk("rep_ball_x", 32'(ball_x), 32'(e.bx));
            chk("rep_ball_y", 32'(ball_y), 32'(e.by));
            chk("rep_ball_w", 32'(ball_w), 32'(e.bw));
            chk("rep_ball_h", 32'(ball_h), 32'(e.bh));
            chk("rep_paddle_found", 32'(paddle_found), 32'(e.pf));
            chk("rep_paddle_x", 32'(paddle_x), 32'(e.px));
            chk("rep_paddle_y", 32'(paddle_y), 32'(e.py));
            chk("rep_frame_count", 32'(frame_count), 32'(e.cnt));
         end
      end
   end

   initial begin
      reset_in = 1'b0;
      pix_en   = 1'b0;
      h_sync   = 1'b1;
      v_sync   = 1'b1;
      rgb      = 12'h000;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // F1: no edge at its start; first vsync edge opens F2
      set_scene_a();
      drive_rows(0, VT);
      chk("f1_locked", 32'(locked), 32'd0);
      drive_rows(0, VT);
      chk("f2_measure_locked", 32'(locked), 32'd0);

      // F3 is the first tracked frame, reported at the F4 edge
      push_exp(1'b1, 10, 12, 8, 8, 1'b0, 0, 0, 1);
      drive_rows(0, VT);
      chk("f3_locked", 32'(locked), 32'd1);
      chk("f3_timing_err", 32'(timing_err), 32'd0);

      // F4: paddle plus ball in the bottom-right corner
      set_scene_b();
      push_exp(1'b1, HA - 1, VA - 1, 1, 1, 1'b1, 2, 5, 2);
      drive_rows(0, VT);

      // F5: black frame, coordinates hold
      set_scene_black();
      push_exp(1'b0, HA - 1, VA - 1, 1, 1, 1'b0, 2, 5, 3);
      drive_rows(0, VT);
      chk("f5_blank_err", 32'(blank_err), 32'd0);

      // F6: blue pixel in the front porch, with idle cycles between pixels
      set_scene_a();
      blank_v = 10;
      gap = 1;
      push_exp(1'b1, 10, 12, 8, 8, 1'b0, 2, 5, 4);
      drive_rows(0, VT);
      chk("f6_blank_err", 32'(blank_err), 32'd1);
      chk("f6_timing_err", 32'(timing_err), 32'd0);
      chk("f6_locked", 32'(locked), 32'd1);

      // F7: one short line; not reported, lock drops at F8 edge
      set_scene_a();
      short_v = 20;
      drive_rows(0, VT);
      chk("f7_timing_err", 32'(timing_err), 32'd1);
      chk("f7_still_locked", 32'(locked), 32'd1);
      set_scene_a();
      drive_rows(0, VT);
      chk("f8_unlocked", 32'(locked), 32'd0);

      // F9: relocked after the clean F8, reported at the F10 edge
      set_scene_b();
      push_exp(1'b1, HA - 1, VA - 1, 1, 1, 1'b1, 2, 5, 5);
      drive_rows(0, VT);
      chk("f9_relocked", 32'(locked), 32'd1);

      // F10: reset in the middle of the ball rows
      set_scene_a();
      drive_rows(0, 21);
      reset_in = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (3) @(posedge clk);
      #1;
      reset_in = 1'b1;
      drive_rows(21, VT);
      drive_rows(0, VT);
      chk("f11_locked", 32'(locked), 32'd0);
      push_exp(1'b1, 10, 12, 8, 8, 1'b0, 0, 0, 1);
      drive_rows(0, VT);
      chk("f12_locked", 32'(locked), 32'd1);
      chk("f12_timing_err", 32'(timing_err), 32'd0);
      chk("f12_blank_err", 32'(blank_err), 32'd0);
      drive_rows(0, 5);

      for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk);
      #1;
      chk("reports_outstanding", 32'(expq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
